// File: rtl/battleship_pkg.sv
// Shared types and constants for the battleship shot sequencer and its key assembler.
package battleship_pkg;

  typedef enum logic [2:0] {
    GET_LETTER, GET_DIGIT, GET_ENTER, FIRE, WAIT_RESULT, UPDATE, GAME_OVER
  } seq_state_e;

  localparam logic [1:0] KEY_LETTER = 2'd0;
  localparam logic [1:0] KEY_DIGIT  = 2'd1;
  localparam logic [1:0] KEY_ENTER  = 2'd2;
  localparam logic [1:0] KEY_CANCEL = 2'd3;

  localparam logic PLAYER_ONE = 1'b0;
  localparam logic PLAYER_TWO = 1'b1;

  localparam int BOARD_DIM = 10;

  // Keyboard digits run 1..9,0 left to right, so digit 0 is the last column.
  function automatic logic [3:0] digit_to_col(input logic [3:0] digit);
    return (digit == 4'd0) ? 4'(BOARD_DIM - 1) : digit - 4'd1;
  endfunction

  function automatic logic [6:0] cell_index(input logic [3:0] row, input logic [3:0] col);
    return 7'(row) * 7'(BOARD_DIM) + 7'(col);
  endfunction

endpackage

// File: rtl/key_assembler.sv
// Collects letter, digit and Enter keys into one coordinate; strobes coord_vld on Enter.
module key_assembler
  import battleship_pkg::*;
(
  input  logic       clock27,
  input  logic       reset,
  input  logic       enable,
  input  logic       key_valid,
  input  logic [1:0] key_kind,
  input  logic [3:0] key_val,
  output logic [1:0] entry_state,
  output logic [3:0] row,
  output logic [3:0] col,
  output logic       coord_vld
);

  seq_state_e state_q, state_d;
  logic [3:0] row_q, row_d, col_q, col_d;
  logic       key_ok;

  assign key_ok = enable && key_valid && (key_val <= 4'd9);

  always_comb begin
    state_d   = state_q;
    row_d     = row_q;
    col_d     = col_q;
    coord_vld = 1'b0;
    if (key_ok) begin
      case (state_q)
        GET_LETTER:
          if (key_kind == KEY_LETTER) begin
            row_d   = key_val;
            state_d = GET_DIGIT;
          end
        GET_DIGIT:
          if (key_kind == KEY_DIGIT) begin
            col_d   = digit_to_col(key_val);
            state_d = GET_ENTER;
          end else if (key_kind == KEY_CANCEL) begin
            row_d   = 4'd0;
            col_d   = 4'd0;
            state_d = GET_LETTER;
          end
        GET_ENTER:
          if (key_kind == KEY_ENTER) begin
            coord_vld = 1'b1;
            state_d   = GET_LETTER;
          end else if (key_kind == KEY_CANCEL) begin
            row_d   = 4'd0;
            col_d   = 4'd0;
            state_d = GET_LETTER;
          end
        default: state_d = GET_LETTER;
      endcase
    end
  end

  always_ff @(posedge clock27 or posedge reset) begin
    if (reset) begin
      state_q <= GET_LETTER;
      row_q   <= 4'd0;
      col_q   <= 4'd0;
    end else begin
      state_q <= state_d;
      row_q   <= row_d;
      col_q   <= col_d;
    end
  end

  assign row = row_q;
  assign col = col_q;
  assign entry_state = (state_q == GET_DIGIT) ? 2'd1 :
                       (state_q == GET_ENTER) ? 2'd2 : 2'd0;

endmodule

// File: rtl/shot_sequencer.sv
// Turn controller: fires assembled shots, waits for hit/miss, scores and alternates turns.
// Optional SHOT_HISTORY_EN adds per-player fired-cell maps and the dup_shot pulse.
module shot_sequencer
  import battleship_pkg::*;
#(
  parameter int SHIP_CELLS     = 17,
  parameter int RESULT_TIMEOUT = 1023,
  parameter int HIT_KEEPS_TURN = 0
) (
  input  logic       clock27,
  input  logic       reset,
  input  logic       key_valid,
  input  logic [1:0] key_kind,
  input  logic [3:0] key_val,
  output logic       shot_valid,
  input  logic       shot_ready,
  output logic [3:0] shot_row,
  output logic [3:0] shot_col,
  output logic       shot_player,
  input  logic       result_valid,
  input  logic       result_hit,
  output logic       player_turn,
  output logic [4:0] hits_p1,
  output logic [4:0] hits_p2,
  output logic       game_over,
  output logic       winner,
  output logic [1:0] entry_state,
  output logic       timeout_err
`ifdef SHOT_HISTORY_EN
  ,
  output logic       dup_shot
`endif
);

  localparam int TW = $clog2(RESULT_TIMEOUT + 1);

  // GET_LETTER here means "entry phase"; the digit/Enter sub-states live in key_assembler.
  seq_state_e state_q, state_d;
  logic [TW-1:0] cnt_q, cnt_d;
  logic       turn_q, turn_d, hit_q, hit_d, tmo_q, tmo_d;
  logic       go_q, go_d, win_q, win_d;
  logic [4:0] hits_p1_q, hits_p1_d, hits_p2_q, hits_p2_d, new_hits;
  logic [1:0] asm_entry;
  logic [3:0] asm_row, asm_col;
  logic       coord_vld;

`ifdef SHOT_HISTORY_EN
  logic [1:0][99:0] map_q, map_d;
  logic dup_q, dup_d;
  logic [6:0] cell;
  assign cell = cell_index(asm_row, asm_col);
`endif

  key_assembler u_keys (
    .clock27     (clock27),
    .reset       (reset),
    .enable      (state_q == GET_LETTER),
    .key_valid   (key_valid),
    .key_kind    (key_kind),
    .key_val     (key_val),
    .entry_state (asm_entry),
    .row         (asm_row),
    .col         (asm_col),
    .coord_vld   (coord_vld)
  );

  assign new_hits = (turn_q ? hits_p2_q : hits_p1_q) + 5'(hit_q);

  always_comb begin
    state_d   = state_q;
    cnt_d     = '0;
    turn_d    = turn_q;
    hit_d     = hit_q;
    tmo_d     = 1'b0;
    go_d      = go_q;
    win_d     = win_q;
    hits_p1_d = hits_p1_q;
    hits_p2_d = hits_p2_q;
`ifdef SHOT_HISTORY_EN
    map_d = map_q;
    dup_d = 1'b0;
`endif
    case (state_q)
      GET_LETTER:
        if (coord_vld) begin
`ifdef SHOT_HISTORY_EN
          if (map_q[turn_q][cell]) dup_d = 1'b1;
          else state_d = FIRE;
`else
          state_d = FIRE;
`endif
        end
      FIRE:
        if (shot_ready) begin
          state_d = WAIT_RESULT;
`ifdef SHOT_HISTORY_EN
          map_d[turn_q][cell] = 1'b1;
`endif
        end
      WAIT_RESULT: begin
        cnt_d = cnt_q + 1'b1;
        // A result landing on the timeout cycle takes priority over the timeout.
        if (result_valid) begin
          hit_d   = result_hit;
          state_d = UPDATE;
        end else if (cnt_q == TW'(RESULT_TIMEOUT - 1)) begin
          hit_d   = 1'b0;
          tmo_d   = 1'b1;
          state_d = UPDATE;
        end
      end
      UPDATE: begin
        if (turn_q) hits_p2_d = new_hits;
        else        hits_p1_d = new_hits;
        state_d = GET_LETTER;
        if (hit_q && new_hits == 5'(SHIP_CELLS)) begin
          go_d    = 1'b1;
          win_d   = turn_q;
          state_d = GAME_OVER;
        end else if (!(hit_q && HIT_KEEPS_TURN != 0)) begin
          turn_d = ~turn_q;
        end
      end
      GAME_OVER: state_d = GAME_OVER;
      default:   state_d = GET_LETTER;
    endcase
  end

  always_ff @(posedge clock27 or posedge reset) begin
    if (reset) begin
      state_q   <= GET_LETTER;
      cnt_q     <= '0;
      turn_q    <= PLAYER_ONE;
      hit_q     <= 1'b0;
      tmo_q     <= 1'b0;
      go_q      <= 1'b0;
      win_q     <= 1'b0;
      hits_p1_q <= 5'd0;
      hits_p2_q <= 5'd0;
`ifdef SHOT_HISTORY_EN
      map_q <= '0;
      dup_q <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      turn_q    <= turn_d;
      hit_q     <= hit_d;
      tmo_q     <= tmo_d;
      go_q      <= go_d;
      win_q     <= win_d;
      hits_p1_q <= hits_p1_d;
      hits_p2_q <= hits_p2_d;
`ifdef SHOT_HISTORY_EN
      map_q <= map_d;
      dup_q <= dup_d;
`endif
    end
  end

  // Coordinate registers stay frozen outside entry, so FIRE sees a stable shot.
  assign shot_valid  = (state_q == FIRE);
  assign shot_row    = asm_row;
  assign shot_col    = asm_col;
  assign shot_player = turn_q;
  assign player_turn = turn_q;
  assign hits_p1     = hits_p1_q;
  assign hits_p2     = hits_p2_q;
  assign game_over   = go_q;
  assign winner      = win_q;
  assign timeout_err = tmo_q;
  assign entry_state = (state_q == GET_LETTER) ? asm_entry : 2'd3;
`ifdef SHOT_HISTORY_EN
  assign dup_shot = dup_q;
`endif

endmodule
